// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the SPI responder.
package spi_pkg;

  localparam int SPI_WIDTH       = 32;
  localparam int SPI_SYNC_STAGES = 2;

  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_ABORT     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ACTIVE    = 3'd2,
    ST_DONE      = 3'd3,
    ST_DONE_HOLD = 3'd4
  } state_t;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall detect
// taken from the last two synchronized samples.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stage_reg;
  logic                   prev_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_reg <= {SYNC_STAGES{RESET_LEVEL}};
      prev_reg  <= RESET_LEVEL;
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], pin};
      prev_reg  <= stage_reg[SYNC_STAGES-1];
    end
  end

  assign level = stage_reg[SYNC_STAGES-1];
  assign rise  = stage_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall  = ~stage_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI responder (sclk idles high, ss active-low, drive on fall, sample on rise).
// Optional frame_err output enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mlb,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  input  logic             sclk,
  input  logic             ss,
  input  logic             din,
`ifdef SPI_SLAVE_FRAME_ERR_EN
  output logic             frame_err,
`endif
  output logic             dout
);

  localparam int CNT_W = count_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic din_level, din_rise_unused, din_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_sclk (
    .clock (clock),
    .reset (reset),
    .pin   (sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // ss resets to "selected" so a frame still in flight at reset release is
  // neither mistaken for a fresh ss_fall nor lets ABORT leave early.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_ss (
    .clock (clock),
    .reset (reset),
    .pin   (ss),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_din (
    .clock (clock),
    .reset (reset),
    .pin   (din),
    .level (din_level),
    .rise  (din_rise_unused),
    .fall  (din_fall_unused)
  );

  state_t           state_reg;
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] tx_shift_reg;
  logic [WIDTH-1:0] rx_shift_reg;
  logic [CNT_W-1:0] count_reg;
  logic             order_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic             rx_valid_reg;
  logic             busy_reg;
  logic             dout_reg;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic             frame_err_reg;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_ABORT;
      hold_reg      <= '1;
      tx_shift_reg  <= '1;
      rx_shift_reg  <= '0;
      count_reg     <= '0;
      order_reg     <= MSB_FIRST;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      dout_reg      <= 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_reg <= 1'b0;
`endif
    end else begin
      rx_valid_reg  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_reg <= 1'b0;
`endif
      if (tx_load) begin
        hold_reg <= tx_data;
      end

      case (state_reg)
        ST_ABORT: begin
          busy_reg <= 1'b0;
          dout_reg <= 1'b1;
          if (ss_level) begin
            state_reg <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          busy_reg <= 1'b0;
          dout_reg <= 1'b1;
          if (ss_fall) begin
            state_reg    <= ST_ACTIVE;
            busy_reg     <= 1'b1;
            tx_shift_reg <= tx_load ? tx_data : hold_reg;
            order_reg    <= mlb;
            count_reg    <= '0;
          end
        end

        ST_ACTIVE: begin
          if (sclk_fall) begin
            if (order_reg == MSB_FIRST) begin
              dout_reg     <= tx_shift_reg[WIDTH-1];
              tx_shift_reg <= {tx_shift_reg[WIDTH-2:0], 1'b1};
            end else begin
              dout_reg     <= tx_shift_reg[0];
              tx_shift_reg <= {1'b1, tx_shift_reg[WIDTH-1:1]};
            end
          end
          if (sclk_rise) begin
            if (order_reg == MSB_FIRST) begin
              rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], din_level};
            end else begin
              rx_shift_reg <= {din_level, rx_shift_reg[WIDTH-1:1]};
            end
            count_reg <= count_reg + 1'b1;
          end
          // A final rise coinciding with ss_rise still completes the frame.
          if (sclk_rise && (count_reg == LAST_BIT)) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            dout_reg  <= 1'b1;
          end else if (ss_rise) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            dout_reg      <= 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_reg <= 1'b1;
`endif
          end
        end

        ST_DONE: begin
          busy_reg     <= 1'b0;
          dout_reg     <= 1'b1;
          rx_data_reg  <= rx_shift_reg;
          rx_valid_reg <= 1'b1;
          state_reg    <= ss_level ? ST_IDLE : ST_DONE_HOLD;
        end

        ST_DONE_HOLD: begin
          busy_reg <= 1'b0;
          dout_reg <= 1'b1;
          if (ss_level) begin
            state_reg <= ST_IDLE;
          end
`ifdef SPI_SLAVE_FRAME_ERR_EN
          if (sclk_rise) begin
            frame_err_reg <= 1'b1;
          end
`endif
        end

        default: begin
          state_reg <= ST_ABORT;
          busy_reg  <= 1'b0;
          dout_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign busy     = busy_reg;
  assign dout     = dout_reg;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_err = frame_err_reg;
`endif

  // sclk level is only consumed through its edges.
  logic sclk_level_unused;
  assign sclk_level_unused = sclk_level;

endmodule
